// File: rtl/seq_array_multiplier_if.sv
// Operand/result bundle for seq_array_multiplier.
// Handshake: start is a one-cycle request and is accepted on a rising edge only
// while busy=0; done is a one-cycle pulse marking product as newly valid, and
// product holds its value until the next done.
interface seq_array_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_array_multiplier.sv
// Multi-cycle radix-2 shift-add multiplier, unsigned or two's-complement per
// operation. Magnitudes are multiplied and the sign is applied once at the end,
// so one WIDTH+1-bit adder serves both modes.
module seq_array_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_array_multiplier_if.slave bus,
    output logic [1:0]           o_dbg_state
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     r_product;
    logic [CW-1:0]     r_cnt;
    logic              r_neg;

    logic              w_accept;
    logic              w_last;
    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic [WIDTH-1:0]  w_addend;
    logic [WIDTH:0]    w_sum;
    logic [PW-1:0]     w_acc_next;
    logic [PW-1:0]     w_prod_final;

    // A new request is taken in IDLE or DONE; in CALC every input is ignored.
    assign w_accept = (r_state != S_CALC) && bus.start;
    assign w_last   = (r_state == S_CALC) && (r_cnt == LAST_STEP);

    // Magnitudes: -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
    assign w_a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    assign w_b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

    // One shift-add step: conditional add into the upper half, carry kept, shift right.
    assign w_addend     = r_mplier[0] ? r_mcand : '0;
    assign w_sum        = {1'b0, r_acc[PW-1:WIDTH]} + {1'b0, w_addend};
    assign w_acc_next   = {w_sum, r_acc[WIDTH-1:1]};
    assign w_prod_final = r_neg ? (~w_acc_next + PW'(1)) : w_acc_next;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_next = r_state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.done     = 1'b1;
                w_state_next = bus.start ? S_CALC : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_CALC) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_product <= w_prod_final;
            end
        end
    end

    assign bus.product = r_product;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_seq_array_multiplier.sv
// Randomised and directed bench for seq_array_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_array_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [1:0] dbg4;
    logic [1:0] dbg8;

    logic [7:0]  exp4_q[$];
    int          cyc4_q[$];
    logic [15:0] exp8_q[$];
    int          cyc8_q[$];
    logic [7:0]  last4 = '0;
    logic [15:0] last8 = '0;

    seq_array_multiplier_if #(.WIDTH(4)) bus4();
    seq_array_multiplier_if #(.WIDTH(8)) bus8();

    seq_array_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .o_dbg_state(dbg4)
    );
    seq_array_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8), .o_dbg_state(dbg8)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // reference model: plain integer multiplication
    function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input bit sm);
        int sa, sb;
        sa = sm ? int'($signed(a)) : int'(a);
        sb = sm ? int'($signed(b)) : int'(b);
        return 8'(sa * sb);
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input bit sm);
        int sa, sb;
        sa = sm ? int'($signed(a)) : int'(a);
        sb = sm ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    // driver: called at a negedge, drives one cycle, records accepted requests
    task automatic cycle4(input bit st, input logic [3:0] a, input logic [3:0] b, input bit sm);
        bus4.start = st; bus4.a = a; bus4.b = b; bus4.signed_mode = sm;
        if (st && !bus4.busy && rst_n) begin
            exp4_q.push_back(model4(a, b, sm));
            cyc4_q.push_back(cyc + 1 + 4);
        end
        @(negedge clk);
    endtask

    task automatic cycle8(input bit st, input logic [7:0] a, input logic [7:0] b, input bit sm);
        bus8.start = st; bus8.a = a; bus8.b = b; bus8.signed_mode = sm;
        if (st && !bus8.busy && rst_n) begin
            exp8_q.push_back(model8(a, b, sm));
            cyc8_q.push_back(cyc + 1 + 8);
        end
        @(negedge clk);
    endtask

    task automatic idle4();
        cycle4(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic idle8();
        cycle8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit sm);
        int n = 0;
        while (bus4.busy && n < 20) begin idle4(); n++; end
        cycle4(1'b1, a, b, sm);
        idle4();
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sm);
        int n = 0;
        while (bus8.busy && n < 20) begin idle8(); n++; end
        cycle8(1'b1, a, b, sm);
        idle8();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp4_q.size() != 0 || exp8_q.size() != 0) && n < 40) begin
            bus4.start = 1'b0;
            bus8.start = 1'b0;
            @(negedge clk);
            n++;
        end
        check_eq(name, 64'(exp4_q.size() + exp8_q.size()), 64'd0);
    endtask

    // scoreboard monitor, WIDTH=4
    always @(negedge clk) begin
        if (!rst_n) begin
            last4 = '0;
        end else begin
            if (bus4.done) begin
                if (exp4_q.size() == 0) begin
                    check_eq("done4_unexpected", 64'd1, 64'd0);
                end else begin
                    check_eq("product4", bus4.product, exp4_q.pop_front());
                    check_eq("latency4", 64'(cyc), 64'(cyc4_q.pop_front()));
                end
            end else begin
                check_eq("hold4", bus4.product, last4);
            end
            if (bus4.busy && bus4.done) check_eq("busy_done4", 64'd1, 64'd0);
            last4 = bus4.product;
        end
    end

    // scoreboard monitor, WIDTH=8
    always @(negedge clk) begin
        if (!rst_n) begin
            last8 = '0;
        end else begin
            if (bus8.done) begin
                if (exp8_q.size() == 0) begin
                    check_eq("done8_unexpected", 64'd1, 64'd0);
                end else begin
                    check_eq("product8", bus8.product, exp8_q.pop_front());
                    check_eq("latency8", 64'(cyc), 64'(cyc8_q.pop_front()));
                end
            end else begin
                check_eq("hold8", bus8.product, last8);
            end
            if (bus8.busy && bus8.done) check_eq("busy_done8", 64'd1, 64'd0);
            last8 = bus8.product;
        end
    end

    // main stimulus
    initial begin
        int busy_cnt;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.signed_mode = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy8", bus8.busy, 1'b0);
        check_eq("reset_done8", bus8.done, 1'b0);
        check_eq("reset_product8", bus8.product, 16'h0);
        check_eq("reset_state8", dbg8, 2'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);

        // released with start=0: outputs stay at zero
        for (int i = 0; i < 12; i++) begin
            check_eq("idle_busy4", bus4.busy, 1'b0);
            check_eq("idle_done8", bus8.done, 1'b0);
            check_eq("idle_product4", bus4.product, 8'h0);
            idle4();
        end

        // WIDTH=4 directed: busy lasts exactly 4 cycles
        cycle4(1'b1, 4'd10, 4'd12, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus4.busy) busy_cnt++;
            idle4();
        end
        check_eq("busy_len4", 64'(busy_cnt), 64'd4);
        op4(4'b1010, 4'b1100, 1'b1);
        op4(4'b1000, 4'b0111, 1'b1);
        op4(4'b1000, 4'b1000, 1'b1);
        op4(4'b0000, 4'b1011, 1'b1);
        op4(4'b1111, 4'b1111, 1'b0);
        drain("drain4_directed");

        // WIDTH=4 random with gaps
        for (int i = 0; i < 30; i++) begin
            cycle4(1'($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        drain("drain4_random");

        // WIDTH=8 directed
        op8(8'd255, 8'd255, 1'b0);
        op8(8'h80, 8'h80, 1'b1);
        op8(8'h80, 8'h7F, 1'b1);
        op8(8'd0, 8'd200, 1'b0);
        op8(8'd0, 8'hC8, 1'b1);
        op8(8'hFF, 8'h01, 1'b1);
        drain("drain8_directed");

        // WIDTH=8 start held high with inputs changing every cycle
        for (int i = 0; i < 60; i++) begin
            cycle8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        drain("drain8_streaming");

        // WIDTH=8 random with gaps
        for (int i = 0; i < 120; i++) begin
            cycle8(1'($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        drain("drain8_random");

        // reset three cycles into an operation
        cycle8(1'b1, 8'd77, 8'd201, 1'b0);
        repeat (3) idle8();
        #2 rst_n = 1'b0;
        #1;
        check_eq("midreset_busy8", bus8.busy, 1'b0);
        check_eq("midreset_done8", bus8.done, 1'b0);
        check_eq("midreset_product8", bus8.product, 16'h0);
        exp8_q.delete();
        cyc8_q.delete();
        exp4_q.delete();
        cyc4_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            check_eq("postreset_done8", bus8.done, 1'b0);
            idle8();
        end
        op8(8'hF6, 8'h0D, 1'b1);
        op8(8'd123, 8'd45, 1'b0);
        drain("drain8_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
